axi_lite_mask_slave: RTL

//  AXI4-Lite responder for the fabric mask-register path; the completing end of the mask-transfer initiator's bus.

---
 rtl/axi_lite_pkg.sv | 22 ++
 rtl/axi_lite_mask_regfile.sv | 36 +++
 rtl/axi_lite_mask_slave.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared response codes, FSM state types and strobe-merge helper for the
// AXI4-Lite mask-register slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Byte-lane merge: lanes with a set strobe take new data, others keep old.
  function automatic logic [31:0] apply_strobe(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_mask_regfile.sv
// NUM_REGS x 32-bit mask register array: byte-strobe write, combinational
// read port, full array export and synchronous clear.
module axi_lite_mask_regfile
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   we_i,
  input  logic [IDX_W-1:0]       widx_i,
  input  logic [31:0]            wdata_i,
  input  logic [3:0]             wstrb_i,
  input  logic [IDX_W-1:0]       ridx_i,
  output logic [31:0]            rdata_o,
  output logic [NUM_REGS*32-1:0] regs_o
);

  logic [31:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[widx_i] <= apply_strobe(regs_q[widx_i], wdata_i, wstrb_i);
    end
  end

  assign rdata_o = regs_q[ridx_i];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_export
    assign regs_o[32*gi +: 32] = regs_q[gi];
  end

endmodule

// File: rtl/axi_lite_mask_slave.sv
// AXI4-Lite responder holding the fabric mask registers; exports the array and
// pulses a write notification on every committed in-range write.
module axi_lite_mask_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [ADDR_W-1:0]      s_axi_awaddr,
  input  logic [2:0]             s_axi_awprot,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [DATA_W-1:0]      s_axi_wdata,
  input  logic [3:0]             s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [ADDR_W-1:0]      s_axi_araddr,
  input  logic [2:0]             s_axi_arprot,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [DATA_W-1:0]      s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic                   S_MASK_VALID,
  output logic [31:0]            S_MASK_ADDR,
  output logic [31:0]            S_MASK_DATA,
  output logic [NUM_REGS*32-1:0] S_MASK_REGS
);

  localparam int              IDX_W  = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] WINDOW = ADDR_W'(NUM_REGS * 4);

  logic unused_prot;
  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  wr_state_t          wr_state_q;
  logic               awready_q, wready_q, aw_held_q, w_held_q;
  logic [ADDR_W-1:0]  awaddr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [3:0]         wstrb_q;
  logic               bvalid_q;
  logic [1:0]         bresp_q;
  logic               mask_valid_q;
  logic [31:0]        mask_addr_q, mask_data_q;

  rd_state_t          rd_state_q;
  logic               arready_q, rvalid_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [1:0]         rresp_q;

  logic [31:0]        regs_arr [NUM_REGS];
  logic [31:0]        rd_word;
  logic [IDX_W-1:0]   w_idx, r_idx;
  logic               w_in_range, r_in_range, commit;

  assign w_idx      = awaddr_q[2 +: IDX_W];
  assign r_idx      = s_axi_araddr[2 +: IDX_W];
  assign w_in_range = awaddr_q < WINDOW;
  assign r_in_range = s_axi_araddr < WINDOW;
  assign commit     = (wr_state_q == W_IDLE) && aw_held_q && w_held_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_unpack
    assign regs_arr[gi] = S_MASK_REGS[32*gi +: 32];
  end

  axi_lite_mask_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk_i   (aclk),
    .srst_i  (areset),
    .we_i    (commit && w_in_range),
    .widx_i  (w_idx),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .ridx_i  (r_idx),
    .rdata_o (rd_word),
    .regs_o  (S_MASK_REGS)
  );

  // Write path: AW and W captured independently, committed once both are held.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q   <= W_IDLE;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      mask_valid_q <= 1'b0;
      mask_addr_q  <= '0;
      mask_data_q  <= '0;
    end else begin
      mask_valid_q <= 1'b0;
      case (wr_state_q)
        W_IDLE: begin
          if (awready_q && s_axi_awvalid) begin
            awaddr_q  <= s_axi_awaddr;
            aw_held_q <= 1'b1;
          end
          if (wready_q && s_axi_wvalid) begin
            wdata_q  <= s_axi_wdata;
            wstrb_q  <= s_axi_wstrb;
            w_held_q <= 1'b1;
          end
          awready_q <= !(aw_held_q || (awready_q && s_axi_awvalid));
          wready_q  <= !(w_held_q || (wready_q && s_axi_wvalid));
          if (commit) begin
            bvalid_q   <= 1'b1;
            bresp_q    <= w_in_range ? RESP_OKAY : RESP_SLVERR;
            wr_state_q <= W_RESP;
            if (w_in_range) begin
              mask_valid_q <= 1'b1;
              mask_addr_q  <= 32'(awaddr_q);
              mask_data_q  <= apply_strobe(regs_arr[w_idx], wdata_q, wstrb_q);
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Read path samples the array before any same-edge write lands.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arready_q && s_axi_arvalid) begin
            rdata_q    <= r_in_range ? rd_word : '0;
            rresp_q    <= r_in_range ? RESP_OKAY : RESP_SLVERR;
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rd_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign S_MASK_VALID  = mask_valid_q;
  assign S_MASK_ADDR   = mask_addr_q;
  assign S_MASK_DATA   = mask_data_q;

endmodule
